// File: rtl/i2c_pin_filter.sv
// i2c_pin_filter: pad-side conditioning for the SCL/SDA lines of an I2C master.
// Converts master o/t pairs into open-drain pad enables, synchronises and
// glitch-filters the pad inputs, detects START/STOP, tracks bus-busy and flags
// lines held low for too long.
// Optional arbitration-loss detection is built only when the macro
// I2C_PIN_FILTER_ARB_EN is defined; otherwise arb_lost is tied low.
module i2c_pin_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_W   = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i2c_scl_o,
   input  logic                 i2c_scl_t,
   input  logic                 i2c_sda_o,
   input  logic                 i2c_sda_t,
   output logic                 i2c_scl_i,
   output logic                 i2c_sda_i,
   input  logic                 scl_pad_i,
   input  logic                 sda_pad_i,
   output logic                 scl_pad_o,
   output logic                 scl_pad_t,
   output logic                 sda_pad_o,
   output logic                 sda_pad_t,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   output logic                 start_det,
   output logic                 stop_det,
   output logic                 bus_busy,
   output logic                 scl_stuck,
   output logic                 sda_stuck,
   output logic                 arb_lost
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
   logic                   sclSyncOut, sdaSyncOut;
   logic                   sclFilt_q, sclFilt_d, sdaFilt_q, sdaFilt_d;
   logic [CNT_W-1:0]       sclCnt_q, sclCnt_d, sdaCnt_q, sdaCnt_d;
   logic                   sclPrev_q, sdaPrev_q;
   logic                   startCond, stopCond;
   logic                   startDet_q, stopDet_q;
   logic                   busy_q, busy_d;
   logic [TIMEOUT_W-1:0]   sclLow_q, sclLow_d, sdaLow_q, sdaLow_d;
   logic                   sclStuck_q, sclStuck_d, sdaStuck_q, sdaStuck_d;

   // Open-drain: the pad is only driven (to 0) when the master actively drives low.
   assign scl_pad_o = 1'b0;
   assign sda_pad_o = 1'b0;
   assign scl_pad_t = i2c_scl_t | i2c_scl_o;
   assign sda_pad_t = i2c_sda_t | i2c_sda_o;

   assign sclSyncOut = sclSync_q[SYNC_STAGES-1];
   assign sdaSyncOut = sdaSync_q[SYNC_STAGES-1];

   // Multi-flop synchronisers bring the asynchronous pads into the clock domain, idling high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclSync_q <= '1;
         sdaSync_q <= '1;
      end else begin
         sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_pad_i};
         sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_pad_i};
      end
   end

   // A new level is accepted only after it has persisted for FILTER_LEN consecutive cycles.
   always_comb begin
      sclFilt_d = sclFilt_q;
      sclCnt_d  = sclCnt_q;
      sdaFilt_d = sdaFilt_q;
      sdaCnt_d  = sdaCnt_q;
      if (sclSyncOut == sclFilt_q) begin
         sclCnt_d = '0;
      end else if (sclCnt_q == FILT_LAST) begin
         sclFilt_d = sclSyncOut;
         sclCnt_d  = '0;
      end else begin
         sclCnt_d = sclCnt_q + 1'b1;
      end
      if (sdaSyncOut == sdaFilt_q) begin
         sdaCnt_d = '0;
      end else if (sdaCnt_q == FILT_LAST) begin
         sdaFilt_d = sdaSyncOut;
         sdaCnt_d  = '0;
      end else begin
         sdaCnt_d = sdaCnt_q + 1'b1;
      end
   end

   // Filter state registers; filtered lines idle high like the bus itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclFilt_q <= 1'b1;
         sdaFilt_q <= 1'b1;
         sclCnt_q  <= '0;
         sdaCnt_q  <= '0;
      end else begin
         sclFilt_q <= sclFilt_d;
         sdaFilt_q <= sdaFilt_d;
         sclCnt_q  <= sclCnt_d;
         sdaCnt_q  <= sdaCnt_d;
      end
   end

   // START/STOP need SCL high on both samples so simultaneous SCL/SDA moves are ignored.
   always_comb begin
      startCond = sclPrev_q & sclFilt_q & sdaPrev_q & ~sdaFilt_q;
      stopCond  = sclPrev_q & sclFilt_q & ~sdaPrev_q & sdaFilt_q;
   end

   // Low-run counters saturate; stuck flags compare the next count so they track the filtered line.
   always_comb begin
      sclLow_d   = sclFilt_q ? '0 : ((&sclLow_q) ? sclLow_q : sclLow_q + 1'b1);
      sdaLow_d   = sdaFilt_q ? '0 : ((&sdaLow_q) ? sdaLow_q : sdaLow_q + 1'b1);
      sclStuck_d = (timeout_cycles != '0) && (sclLow_d >= timeout_cycles);
      sdaStuck_d = (timeout_cycles != '0) && (sdaLow_d >= timeout_cycles);
   end

   // A stuck SCL means the transfer is dead, so it overrides START/STOP tracking.
   always_comb begin
      busy_d = busy_q;
      if (sclStuck_d & ~sclStuck_q) begin
         busy_d = 1'b0;
      end else if (startCond) begin
         busy_d = 1'b1;
      end else if (stopCond) begin
         busy_d = 1'b0;
      end
   end

   // Condition pulses, bus-busy and stuck monitoring registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclPrev_q  <= 1'b1;
         sdaPrev_q  <= 1'b1;
         startDet_q <= 1'b0;
         stopDet_q  <= 1'b0;
         busy_q     <= 1'b0;
         sclLow_q   <= '0;
         sdaLow_q   <= '0;
         sclStuck_q <= 1'b0;
         sdaStuck_q <= 1'b0;
      end else begin
         sclPrev_q  <= sclFilt_q;
         sdaPrev_q  <= sdaFilt_q;
         startDet_q <= startCond;
         stopDet_q  <= stopCond;
         busy_q     <= busy_d;
         sclLow_q   <= sclLow_d;
         sdaLow_q   <= sdaLow_d;
         sclStuck_q <= sclStuck_d;
         sdaStuck_q <= sdaStuck_d;
      end
   end

`ifdef I2C_PIN_FILTER_ARB_EN
   logic arbLost_q;

   // Arbitration is lost when we released SDA but the bus shows it low on a rising SCL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arbLost_q <= 1'b0;
      end else begin
         arbLost_q <= ~sclPrev_q & sclFilt_q & busy_q & (i2c_sda_t | i2c_sda_o) & ~sdaFilt_q;
      end
   end

   assign arb_lost = arbLost_q;
`else
   assign arb_lost = 1'b0;
`endif

   assign i2c_scl_i = sclFilt_q;
   assign i2c_sda_i = sdaFilt_q;
   assign start_det = startDet_q;
   assign stop_det  = stopDet_q;
   assign bus_busy  = busy_q;
   assign scl_stuck = sclStuck_q;
   assign sda_stuck = sdaStuck_q;

endmodule

// File: tb/tb_i2c_pin_filter.sv
// tb_i2c_pin_filter: directed scenarios plus randomized pad traffic checked
// against a window-based behavioural model of the pin filter.
module tb_i2c_pin_filter;

   localparam int S    = 2;
   localparam int FL   = 4;
   localparam int TW   = 20;
   localparam int MAXC = (1 << TW) - 1;
`ifdef I2C_PIN_FILTER_ARB_EN
   localparam bit ARB = 1'b1;
`else
   localparam bit ARB = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
   logic          i2c_scl_i, i2c_sda_i;
   logic          scl_pad_i, sda_pad_i;
   logic          scl_pad_o, scl_pad_t, sda_pad_o, sda_pad_t;
   logic [TW-1:0] timeout_cycles;
   logic          start_det, stop_det, bus_busy, scl_stuck, sda_stuck, arb_lost;

   int checks   = 0;
   int failures = 0;

   // Reference model state: values as seen just after each clock edge.
   bit padQScl[$], padQSda[$];
   bit winScl[$], winSda[$];
   bit mSScl, mSSda, mFScl, mFSda, mPScl, mPSda;
   bit mStart, mStop, mBusy, mStuckScl, mStuckSda, mArb;
   int mCntScl, mCntSda;

   i2c_pin_filter #(.SYNC_STAGES(S), .FILTER_LEN(FL), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst),
      .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
      .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
      .i2c_scl_i(i2c_scl_i), .i2c_sda_i(i2c_sda_i),
      .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
      .scl_pad_o(scl_pad_o), .scl_pad_t(scl_pad_t),
      .sda_pad_o(sda_pad_o), .sda_pad_t(sda_pad_t),
      .timeout_cycles(timeout_cycles),
      .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
      .scl_stuck(scl_stuck), .sda_stuck(sda_stuck), .arb_lost(arb_lost)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic modelReset();
      padQScl = {};
      padQSda = {};
      for (int i = 0; i < S; i++) begin
         padQScl.push_back(1'b1);
         padQSda.push_back(1'b1);
      end
      winScl = {};
      winSda = {};
      mSScl = 1; mSSda = 1; mFScl = 1; mFSda = 1; mPScl = 1; mPSda = 1;
      mStart = 0; mStop = 0; mBusy = 0; mStuckScl = 0; mStuckSda = 0; mArb = 0;
      mCntScl = 0; mCntSda = 0;
   endtask

   // Model of one clock edge: pads are delayed S cycles, a level is accepted once the last FL
   // synchronised samples all disagree with the current filtered level.
   task automatic modelEdge();
      bit fOldScl, fOldSda, pOldScl, pOldSda, busyOld, stuckOld, allScl, allSda;
      fOldScl = mFScl; fOldSda = mFSda; pOldScl = mPScl; pOldSda = mPSda;
      busyOld = mBusy; stuckOld = mStuckScl;
      winScl.push_front(mSScl);
      winSda.push_front(mSSda);
      if (winScl.size() > FL) void'(winScl.pop_back());
      if (winSda.size() > FL) void'(winSda.pop_back());
      allScl = (winScl.size() == FL);
      allSda = (winSda.size() == FL);
      foreach (winScl[i]) if (winScl[i] == fOldScl) allScl = 0;
      foreach (winSda[i]) if (winSda[i] == fOldSda) allSda = 0;
      if (allScl) mFScl = ~fOldScl;
      if (allSda) mFSda = ~fOldSda;
      padQScl.push_front(scl_pad_i);
      padQSda.push_front(sda_pad_i);
      void'(padQScl.pop_back());
      void'(padQSda.pop_back());
      mSScl = padQScl[S-1];
      mSSda = padQSda[S-1];
      mStart = pOldScl && fOldScl && pOldSda && !fOldSda;
      mStop  = pOldScl && fOldScl && !pOldSda && fOldSda;
      mPScl = fOldScl;
      mPSda = fOldSda;
      mCntScl = fOldScl ? 0 : ((mCntScl == MAXC) ? MAXC : mCntScl + 1);
      mCntSda = fOldSda ? 0 : ((mCntSda == MAXC) ? MAXC : mCntSda + 1);
      mStuckScl = (timeout_cycles != 0) && (mCntScl >= int'(timeout_cycles));
      mStuckSda = (timeout_cycles != 0) && (mCntSda >= int'(timeout_cycles));
      mArb = ARB && !pOldScl && fOldScl && busyOld && (i2c_sda_t || i2c_sda_o) && !fOldSda;
      if (mStuckScl && !stuckOld) mBusy = 0;
      else if (mStart) mBusy = 1;
      else if (mStop) mBusy = 0;
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   task automatic test_reset();
      scl_pad_i = 1; sda_pad_i = 1;
      i2c_scl_t = 1; i2c_scl_o = 0; i2c_sda_t = 1; i2c_sda_o = 0;
      timeout_cycles = '0;
      rst = 1'b1;
      #1;
      checks++;
      if ({i2c_scl_i, i2c_sda_i} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL reset_lines got=%b exp=11", {i2c_scl_i, i2c_sda_i});
      end
      checks++;
      if ({start_det, stop_det, bus_busy, scl_stuck, sda_stuck, arb_lost} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got=%b exp=000000",
                  {start_det, stop_det, bus_busy, scl_stuck, sda_stuck, arb_lost});
      end
      checks++;
      if ({scl_pad_t, sda_pad_t} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL reset_pad_t got=%b exp=11", {scl_pad_t, sda_pad_t});
      end
      doReset();
      repeat (10) step();
      checks++;
      if ({i2c_scl_i, i2c_sda_i, bus_busy} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL idle_after_reset got=%b exp=110", {i2c_scl_i, i2c_sda_i, bus_busy});
      end
   endtask

   task automatic test_pad_drive();
      bit t1, o1, t2, o2;
      for (int n = 0; n < 16; n++) begin
         t1 = 1'($urandom); o1 = 1'($urandom); t2 = 1'($urandom); o2 = 1'($urandom);
         if (n == 0) begin t1 = 0; o1 = 0; t2 = 0; o2 = 0; end
         if (n == 1) begin t1 = 0; o1 = 1; t2 = 0; o2 = 1; end
         i2c_scl_t = t1; i2c_scl_o = o1; i2c_sda_t = t2; i2c_sda_o = o2;
         #1;
         checks++;
         if ({scl_pad_t, sda_pad_t, scl_pad_o, sda_pad_o} !== {t1 | o1, t2 | o2, 2'b00}) begin
            failures++;
            $display("[TB] FAIL pad_drive got=%b exp=%b",
                     {scl_pad_t, sda_pad_t, scl_pad_o, sda_pad_o}, {t1 | o1, t2 | o2, 2'b00});
         end
         step();
      end
      i2c_scl_t = 1; i2c_scl_o = 0; i2c_sda_t = 1; i2c_sda_o = 0;
      repeat (4) step();
   endtask

   task automatic test_filter();
      int sawLow, starts, lat;
      timeout_cycles = '0;
      sawLow = 0; starts = 0; lat = -1;
      sda_pad_i = 0;
      repeat (3) step();
      sda_pad_i = 1;
      for (int n = 0; n < 12; n++) begin
         step();
         if (i2c_sda_i !== 1'b1) sawLow++;
         if (start_det === 1'b1) starts++;
      end
      checks++;
      if (sawLow != 0) begin
         failures++;
         $display("[TB] FAIL glitch_reject low_cycles=%0d exp=0", sawLow);
      end
      checks++;
      if (starts != 0) begin
         failures++;
         $display("[TB] FAIL glitch_no_start pulses=%0d exp=0", starts);
      end
      sda_pad_i = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (lat < 0 && i2c_sda_i === 1'b0) lat = n;
         if (start_det === 1'b1) starts++;
      end
      checks++;
      if (lat != S + FL) begin
         failures++;
         $display("[TB] FAIL filter_latency got=%0d exp=%0d", lat, S + FL);
      end
      checks++;
      if (starts != 1) begin
         failures++;
         $display("[TB] FAIL start_pulse pulses=%0d exp=1", starts);
      end
      checks++;
      if (bus_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_after_start got=%b exp=1", bus_busy);
      end
   endtask

   task automatic test_stop();
      int stops, others;
      stops = 0; others = 0;
      sda_pad_i = 1;
      for (int n = 0; n < 15; n++) begin
         step();
         if (stop_det === 1'b1) stops++;
         if (start_det === 1'b1) others++;
      end
      checks++;
      if (stops != 1 || others != 0) begin
         failures++;
         $display("[TB] FAIL stop_pulse stops=%0d starts=%0d exp=1/0", stops, others);
      end
      checks++;
      if (bus_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL busy_after_stop got=%b exp=0", bus_busy);
      end
      others = 0;
      scl_pad_i = 0; sda_pad_i = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (start_det === 1'b1 || stop_det === 1'b1) others++;
      end
      scl_pad_i = 1; sda_pad_i = 1;
      for (int n = 0; n < 15; n++) begin
         step();
         if (start_det === 1'b1 || stop_det === 1'b1) others++;
      end
      checks++;
      if (others != 0 || bus_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL simultaneous_toggle pulses=%0d busy=%b exp=0/0", others, bus_busy);
      end
   endtask

   task automatic test_stuck();
      int fallEdge, stuckEdge, riseEdge, clrEdge, anyStuck;
      logic busyBefore, busyAt;
      timeout_cycles = '0;
      sda_pad_i = 0;
      repeat (12) step();
      checks++;
      if (bus_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stuck_setup_busy got=%b exp=1", bus_busy);
      end
      timeout_cycles = TW'(100);
      scl_pad_i = 0;
      fallEdge = -1; stuckEdge = -1; busyBefore = 1'b0; busyAt = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         step();
         if (fallEdge < 0 && i2c_scl_i === 1'b0) fallEdge = n;
         if (stuckEdge < 0 && scl_stuck === 1'b1) begin
            stuckEdge = n;
            busyAt = bus_busy;
         end
         if (stuckEdge < 0) busyBefore = bus_busy;
      end
      checks++;
      if (stuckEdge < 0 || stuckEdge - fallEdge != 100) begin
         failures++;
         $display("[TB] FAIL stuck_threshold fall=%0d stuck=%0d exp_delta=100", fallEdge, stuckEdge);
      end
      checks++;
      if (busyBefore !== 1'b1 || busyAt !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stuck_clears_busy before=%b at=%b exp=1/0", busyBefore, busyAt);
      end
      scl_pad_i = 1;
      riseEdge = -1; clrEdge = -1;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (riseEdge < 0 && i2c_scl_i === 1'b1) riseEdge = n;
         if (clrEdge < 0 && scl_stuck === 1'b0) clrEdge = n;
      end
      checks++;
      if (riseEdge < 0 || clrEdge - riseEdge != 1) begin
         failures++;
         $display("[TB] FAIL stuck_release rise=%0d clear=%0d exp_delta=1", riseEdge, clrEdge);
      end
      sda_pad_i = 1;
      repeat (12) step();
      timeout_cycles = '0;
      anyStuck = 0;
      scl_pad_i = 0;
      for (int n = 0; n < 250; n++) begin
         step();
         if (scl_stuck !== 1'b0) anyStuck++;
      end
      scl_pad_i = 1;
      repeat (12) step();
      checks++;
      if (anyStuck != 0) begin
         failures++;
         $display("[TB] FAIL stuck_disabled asserted_cycles=%0d exp=0", anyStuck);
      end
   endtask

   task automatic test_arb();
      int arbs;
      logic busyPre;
      doReset();
      timeout_cycles = '0;
      sda_pad_i = 0;
      repeat (12) step();
      scl_pad_i = 0;
      repeat (12) step();
      busyPre = bus_busy;
      i2c_sda_t = 1; i2c_sda_o = 1;
      scl_pad_i = 1;
      arbs = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (arb_lost === 1'b1) arbs++;
      end
      checks++;
      if (busyPre !== 1'b1 || arbs != (ARB ? 1 : 0)) begin
         failures++;
         $display("[TB] FAIL arb_released busy=%b pulses=%0d exp=1/%0d", busyPre, arbs, ARB ? 1 : 0);
      end
      i2c_sda_t = 0; i2c_sda_o = 0;
      scl_pad_i = 0;
      repeat (12) step();
      scl_pad_i = 1;
      arbs = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (arb_lost !== 1'b0) arbs++;
      end
      checks++;
      if (arbs != 0) begin
         failures++;
         $display("[TB] FAIL arb_driving pulses=%0d exp=0", arbs);
      end
      i2c_sda_t = 1; i2c_sda_o = 0;
      sda_pad_i = 1;
      repeat (12) step();
   endtask

   task automatic test_reset_mid();
      int stops;
      sda_pad_i = 0;
      repeat (12) step();
      rst = 1'b1;
      sda_pad_i = 1;
      #1;
      checks++;
      if ({bus_busy, stop_det, i2c_sda_i} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL reset_mid got=%b exp=001", {bus_busy, stop_det, i2c_sda_i});
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      stops = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (stop_det !== 1'b0 || bus_busy !== 1'b0) stops++;
      end
      checks++;
      if (stops != 0) begin
         failures++;
         $display("[TB] FAIL reset_mid_no_stop bad_cycles=%0d exp=0", stops);
      end
   endtask

   task automatic test_random();
      int holdScl, holdSda;
      logic [7:0] obs, exp;
      doReset();
      holdScl = 0; holdSda = 0;
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) timeout_cycles = TW'($urandom_range(0, 40));
         if (holdScl == 0) begin
            scl_pad_i = ~scl_pad_i;
            holdScl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
         end
         if (holdSda == 0) begin
            sda_pad_i = ~sda_pad_i;
            holdSda = ($urandom_range(0, 15) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
         end
         holdScl--;
         holdSda--;
         if ($urandom_range(0, 7) == 0) begin
            i2c_sda_t = 1'($urandom); i2c_sda_o = 1'($urandom);
            i2c_scl_t = 1'($urandom); i2c_scl_o = 1'($urandom);
         end
         step();
         obs = {i2c_scl_i, i2c_sda_i, start_det, stop_det, bus_busy, scl_stuck, sda_stuck, arb_lost};
         exp = {mFScl, mFSda, mStart, mStop, mBusy, mStuckScl, mStuckSda, mArb};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL random_outputs cycle=%0d got=%b exp=%b", n, obs, exp);
         end
         checks++;
         if ({scl_pad_t, sda_pad_t, scl_pad_o, sda_pad_o} !==
             {i2c_scl_t | i2c_scl_o, i2c_sda_t | i2c_sda_o, 2'b00}) begin
            failures++;
            $display("[TB] FAIL random_pads cycle=%0d got=%b", n,
                     {scl_pad_t, sda_pad_t, scl_pad_o, sda_pad_o});
         end
      end
   endtask

   // Runs every scenario in order and reports the totals.
   initial begin
      rst = 1'b1;
      scl_pad_i = 1; sda_pad_i = 1;
      i2c_scl_t = 1; i2c_scl_o = 0; i2c_sda_t = 1; i2c_sda_o = 0;
      timeout_cycles = '0;
      modelReset();
      $display("[TB] starting i2c_pin_filter bench (ARB build=%0d)", ARB);
      test_reset();
      test_pad_drive();
      test_filter();
      test_stop();
      test_stuck();
      test_arb();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
